// File: rtl/instr_executor_if.sv
// Shared types and the start/fetch/result bus of the instruction executor.
package instr_executor_pkg;

   typedef enum logic [3:0] {
      OpZero  = 4'd0,
      OpPassA = 4'd1,
      OpPassB = 4'd2,
      OpAdd   = 4'd3,
      OpSub   = 4'd4,
      OpMult  = 4'd5,
      OpDiv   = 4'd6,
      OpMod   = 4'd7
   } opcode_t;

   typedef struct packed {
      opcode_t            opc;
      logic signed [31:0] op_a;
      logic signed [31:0] op_b;
   } instr_t;

endpackage

interface instr_executor_if;
   import instr_executor_pkg::*;

   logic               start;
   logic [4:0]         start_addr;
   logic [5:0]         count;
   logic [4:0]         read_pointer;
   instr_t             instruction_word;
   logic signed [63:0] result;
   logic [4:0]         result_addr;
   logic               result_valid;
   logic               result_ready;
   logic               div_err;
   logic               busy;
   logic               done;

   // Requester / instruction register / result consumer side.
   modport master (
      output start, start_addr, count, instruction_word, result_ready,
      input  read_pointer, result, result_addr, result_valid, div_err, busy, done
   );

   // Executor side.
   modport slave (
      input  start, start_addr, count, instruction_word, result_ready,
      output read_pointer, result, result_addr, result_valid, div_err, busy, done
   );

endinterface

// File: rtl/instr_executor.sv
// Batch instruction executor: fetches count instructions from consecutive
// register locations, executes each one and hands results out over a
// valid/ready handshake, one result every three cycles at best.
module instr_executor
   import instr_executor_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32
) (
   input logic              clk,
   input logic              reset,
   instr_executor_if.slave  bus
);

   localparam logic [5:0] MaxCount = 6'(NUM_REGS);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StResp,
      StDone
   } state_e;

   state_e             state_q, state_d;
   logic [4:0]         rptr_q, rptr_d;
   logic [5:0]         remaining_q, remaining_d;
   instr_t             instr_q, instr_d;
   logic [4:0]         addr_q, addr_d;
   logic signed [63:0] result_q, result_d;
   logic [4:0]         result_addr_q, result_addr_d;
   logic               div_err_q, div_err_d;

   logic signed [63:0] a64, b64;
   logic signed [63:0] exec_result;
   logic               exec_div_err;
   logic               start_ok;

   assign a64 = {{32{instr_q.op_a[31]}}, instr_q.op_a};
   assign b64 = {{32{instr_q.op_b[31]}}, instr_q.op_b};

   assign start_ok = bus.start && (bus.count != 6'd0) && (bus.count <= MaxCount);

   // Arithmetic on the captured instruction; a zero divisor yields 0 and flags div_err.
   always_comb begin
      exec_result  = '0;
      exec_div_err = 1'b0;
      case (instr_q.opc)
         OpZero:  exec_result = '0;
         OpPassA: exec_result = a64;
         OpPassB: exec_result = b64;
         OpAdd:   exec_result = a64 + b64;
         OpSub:   exec_result = a64 - b64;
         OpMult:  exec_result = a64 * b64;
         OpDiv: begin
            if (b64 == 64'sd0) begin
               exec_div_err = 1'b1;
            end else begin
               exec_result = a64 / b64;
            end
         end
         OpMod: begin
            if (b64 == 64'sd0) begin
               exec_div_err = 1'b1;
            end else begin
               exec_result = a64 % b64;
            end
         end
         default: exec_result = '0;
      endcase
   end

   // Next-state and datapath update for the batch sequencer.
   always_comb begin
      state_d       = state_q;
      rptr_d        = rptr_q;
      remaining_d   = remaining_q;
      instr_d       = instr_q;
      addr_d        = addr_q;
      result_d      = result_q;
      result_addr_d = result_addr_q;
      div_err_d     = div_err_q;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               rptr_d      = bus.start_addr;
               remaining_d = bus.count;
               state_d     = StFetch;
            end
         end
         StFetch: begin
            instr_d = bus.instruction_word;
            addr_d  = rptr_q;
            state_d = StExec;
         end
         StExec: begin
            result_d      = exec_result;
            div_err_d     = exec_div_err;
            result_addr_d = addr_q;
            state_d       = StResp;
         end
         StResp: begin
            if (bus.result_ready) begin
               remaining_d = remaining_q - 6'd1;
               if (remaining_d != 6'd0) begin
                  // 5-bit pointer wraps 31 -> 0 on its own.
                  rptr_d  = rptr_q + 5'd1;
                  state_d = StFetch;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         rptr_q        <= '0;
         remaining_q   <= '0;
         instr_q       <= '0;
         addr_q        <= '0;
         result_q      <= '0;
         result_addr_q <= '0;
         div_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         rptr_q        <= rptr_d;
         remaining_q   <= remaining_d;
         instr_q       <= instr_d;
         addr_q        <= addr_d;
         result_q      <= result_d;
         result_addr_q <= result_addr_d;
         div_err_q     <= div_err_d;
      end
   end

   assign bus.read_pointer = rptr_q;
   assign bus.result       = result_q;
   assign bus.result_addr  = result_addr_q;
   assign bus.div_err      = div_err_q;
   assign bus.result_valid = (state_q == StResp);
   assign bus.busy         = (state_q != StIdle);
   assign bus.done         = (state_q == StDone);

endmodule

// File: doc/instr_executor.md
INSTR_EXECUTOR -- requirements
Module: instr_executor

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, the instruction-register depth; the address width is 5 bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit; a one-cycle request to execute a batch.
REQ-005 SHALL have port start_addr, input, 5 bits; the first register location to read.
REQ-006 SHALL have port count, input, 6 bits; the number of instructions to execute, valid range 1..32.
REQ-007 SHALL have port read_pointer, output, 5 bits; the address driven to the instruction register.
REQ-008 SHALL have port instruction_word, input, a struct with opc (opcode_t, 4 bits), op_a (signed 32 bits) and op_b (signed 32 bits); it is returned by the instruction register.
REQ-009 SHALL have port result, output, signed 64 bits; the executed value.
REQ-010 SHALL have port result_addr, output, 5 bits; the location the current result came from.
REQ-011 SHALL have port result_valid, output, 1 bit; result is presented.
REQ-012 SHALL have port result_ready, input, 1 bit; the consumer accepts the result.
REQ-013 SHALL have port div_err, output, 1 bit; set when the current result came from DIV or MOD with op_b equal to 0.
REQ-014 SHALL have port busy, output, 1 bit; high whenever the FSM is not in IDLE.
REQ-015 SHALL have port done, output, 1 bit; a one-cycle pulse when the batch completes.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, EXEC, RESP and DONE.
REQ-017 SHALL, in IDLE, on start=1 with count in 1..32: latch start_addr into read_pointer, latch count into a remaining counter, and go to FETCH.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL treat start with count=0 or count>32 as a no-op: the FSM stays in IDLE and done is not pulsed.
REQ-020 SHALL, in FETCH (one cycle), capture instruction_word and read_pointer into internal registers at the end of the cycle, then go to EXEC.
REQ-021 SHALL, in EXEC (one cycle), compute the result, register it into result, result_addr and div_err, and go to RESP.
REQ-022 SHALL compute results per opcode, with operands sign-extended to 64 bits:
  - ZERO: 0
  - PASSA: op_a
  - PASSB: op_b
  - ADD: op_a+op_b
  - SUB: op_a-op_b
  - MULT: op_a*op_b (full 64-bit product)
  - DIV: op_a/op_b (truncate toward zero)
  - MOD: op_a%op_b (sign follows op_a)
  - any undefined opcode: 0
REQ-023 SHALL make DIV or MOD with op_b=0 produce result=0 and div_err=1; div_err SHALL be 0 for every other result.
REQ-024 SHALL, in RESP, hold result_valid=1 and keep result, result_addr and div_err stable until result_ready=1 is sampled.
REQ-025 SHALL, on the RESP handshake, decrement remaining; if remaining becomes nonzero, increment read_pointer and go to FETCH, otherwise go to DONE.
REQ-026 SHALL wrap read_pointer from 31 to 0 when it is incremented.
REQ-027 SHALL, in DONE, pulse done=1 for exactly one cycle and then return to IDLE.
REQ-028 SHALL accept a start arriving in the DONE cycle on the following IDLE cycle only.
REQ-029 SHALL keep latency from start sampled to result_valid=1 at exactly 3 cycles; with result_ready held at 1, each subsequent result SHALL follow every 3 cycles.
REQ-030 SHALL deassert result_valid in the cycle after the handshake.
REQ-031 SHALL never change read_pointer while in FETCH.

Reset
REQ-032 SHALL, on reset=1 at a rising edge, force state to IDLE and set read_pointer=0, result=0, result_addr=0, result_valid=0, div_err=0, busy=0, done=0 and remaining=0.
REQ-033 SHALL let reset asserted mid-batch (any state) abort the batch with no done pulse; the outputs take their REQ-032 values on the next edge.
REQ-034 SHALL let reset take priority over start in the same cycle.

Verification
REQ-035 SHALL verify single ADD: location 0 = {ADD, 7, -3}, start_addr=0, count=1, result_ready=1 -> result_valid 3 cycles after start, result=4, result_addr=0, done pulses on the next cycle.
REQ-036 SHALL verify a batch of 3 in-order instructions: locations 0..2 = {MULT,-5,6}, {SUB,2,9}, {PASSB,1,15} -> results -30, -7, 15 with result_addr 0, 1, 2.
REQ-037 SHALL verify division by zero: {DIV,12,0} and {MOD,-7,0} -> result=0 and div_err=1 for both; {MOD,-7,2} -> result=-1 and div_err=0.
REQ-038 SHALL verify wrap-around and backpressure: start_addr=30, count=4 -> result_addr 30, 31, 0, 1; with result_ready held low 5 cycles on the second result, result stays stable and no results are skipped.
REQ-039 SHALL verify reset mid-batch: count=8, reset asserted in EXEC of the third instruction -> next cycle busy=0, result_valid=0, read_pointer=0, and no done pulse.
REQ-040 SHALL verify start while busy and an invalid count: start during a batch changes nothing; start with count=0 in IDLE -> busy stays 0.
